// File: rtl/led_sequencer.sv
// LED pattern sequencer: a prescaler produces a step tick, and each tick advances the
// pattern by the current mode (rotate left/right, bounce, blink). The mode and the step
// period are reloaded through a valid/ready command port. LED outputs are active-low.
module led_sequencer #(
  parameter int unsigned N_LEDS    = 6,
  parameter int unsigned DIV_WIDTH = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic [DIV_WIDTH-1:0] cmd_period,
  output logic                 tick,
  output logic [N_LEDS-1:0]    led
);

  typedef enum logic {StRun, StLoad} state_e;
  typedef enum logic [1:0] {ModeRotL, ModeRotR, ModeBounce, ModeBlink} mode_e;

  state_e                 state_q;
  mode_e                  mode_q;
  logic [DIV_WIDTH-1:0]   period_q;
  logic [DIV_WIDTH-1:0]   cnt_q;
  logic [N_LEDS-1:0]      pat_q;
  logic                   dir_q;
  logic                   tick_q;

  logic [N_LEDS-1:0]      step_pat;
  logic                   step_dir;
  logic [N_LEDS-1:0]      load_pat;
  logic                   step_due;

  localparam logic [N_LEDS-1:0] PatLsb = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [N_LEDS-1:0] PatMsb = {1'b1, {(N_LEDS-1){1'b0}}};

  assign step_due  = (cnt_q == period_q);
  assign cmd_ready = (state_q == StRun);
  assign tick      = tick_q;
  assign led       = ~pat_q;

  // Next pattern and bounce direction for one step under the current mode.
  always_comb begin
    step_pat = pat_q;
    step_dir = dir_q;
    case (mode_q)
      ModeRotL: step_pat = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
      ModeRotR: step_pat = {pat_q[0], pat_q[N_LEDS-1:1]};
      ModeBounce: begin
        if (!dir_q) begin
          // Turn at the MSB so the end position is shown only once.
          if (pat_q[N_LEDS-1]) begin
            step_dir = 1'b1;
            step_pat = pat_q >> 1;
          end else begin
            step_pat = pat_q << 1;
          end
        end else begin
          if (pat_q[0]) begin
            step_dir = 1'b0;
            step_pat = pat_q << 1;
          end else begin
            step_pat = pat_q >> 1;
          end
        end
      end
      ModeBlink: step_pat = ~pat_q;
      default: step_pat = pat_q;
    endcase
  end

  // Starting pattern installed when leaving LOAD, chosen by the newly loaded mode.
  always_comb begin
    load_pat = PatLsb;
    case (mode_q)
      ModeRotL, ModeBounce: load_pat = PatLsb;
      ModeRotR:             load_pat = PatMsb;
      ModeBlink:            load_pat = '1;
      default:              load_pat = PatLsb;
    endcase
  end

  // Control FSM, prescaler and pattern registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      mode_q   <= ModeRotL;
      period_q <= '1;
      cnt_q    <= '0;
      pat_q    <= PatLsb;
      dir_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          // A step due on the accept edge still runs under the old mode; LOAD overwrites it.
          if (step_due) begin
            cnt_q  <= '0;
            pat_q  <= step_pat;
            dir_q  <= step_dir;
            tick_q <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= 1'b0;
          end
          if (cmd_valid) begin
            mode_q   <= mode_e'(cmd_mode);
            period_q <= cmd_period;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          cnt_q   <= '0;
          dir_q   <= 1'b0;
          pat_q   <= load_pat;
          tick_q  <= 1'b0;
          state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer with N_LEDS = 4, DIV_WIDTH = 4. The model treats the pattern as a
// pure function of (mode, steps since load) and step timing as elapsed cycles modulo period+1.
module tb_led_sequencer;

  localparam int N  = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_mode = 2'd0;
  logic [DW-1:0] cmd_period = '0;
  logic          tick;
  logic [N-1:0]  led;

  led_sequencer #(
    .N_LEDS   (N),
    .DIV_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_period(cmd_period),
    .tick      (tick),
    .led       (led)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_bad   = 0;
  int dut_acc = 0;
  bit run_chk = 1'b0;

  // Model state.
  int     m_mode       = 0;
  int     m_k          = 0;
  int     m_period     = 15;
  int     m_new_mode   = 0;
  int     m_new_period = 0;
  longint m_elapsed    = 0;
  bit     m_load       = 1'b0;
  bit     m_tick       = 1'b0;

  // Pattern after k steps from the mode's starting pattern.
  function automatic logic [N-1:0] model_pat(input int m, input int k);
    logic [N-1:0] one;
    int p;
    one = {{(N-1){1'b0}}, 1'b1};
    case (m)
      0: return one << (k % N);
      1: return one << (N - 1 - (k % N));
      2: begin
        p = k % (2 * N - 2);
        return one << ((p < N) ? p : (2 * N - 2 - p));
      end
      default: return ((k % 2) == 0) ? '1 : '0;
    endcase
  endfunction

  function automatic logic [N-1:0] model_led(input int m, input int k);
    return ~model_pat(m, k);
  endfunction

  function automatic bit step_now(input longint e, input int p);
    return (e % longint'(p + 1)) == longint'(p);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int m, input int p);
    cmd_mode   = 2'(m);
    cmd_period = DW'(p);
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  // Behavioural model, updated on the same edges as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode    <= 0;
      m_k       <= 0;
      m_period  <= 15;
      m_elapsed <= 0;
      m_load    <= 1'b0;
      m_tick    <= 1'b0;
    end else if (m_load) begin
      m_load    <= 1'b0;
      m_mode    <= m_new_mode;
      m_period  <= m_new_period;
      m_k       <= 0;
      m_elapsed <= 0;
      m_tick    <= 1'b0;
    end else begin
      m_tick <= step_now(m_elapsed, m_period);
      if (step_now(m_elapsed, m_period)) m_k <= m_k + 1;
      m_elapsed <= m_elapsed + 1;
      if (cmd_valid) begin
        m_load       <= 1'b1;
        m_new_mode   <= int'(cmd_mode);
        m_new_period <= int'(cmd_period);
      end
    end
  end

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) dut_acc <= dut_acc + 1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      check("model_led", 32'(led), 32'(model_led(m_mode, m_k)));
      check("model_ready", 32'(cmd_ready), 32'(!m_load));
      check("model_tick", 32'(tick), 32'(m_tick));
    end
  end

  logic [N-1:0] rr_pat[4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
  logic [N-1:0] bn_pat[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                             4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic [N-1:0] v;
  int           acc0;

  initial begin
    // Reset, no command.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_chk = 1'b1;
    check("rst_led", 32'(led), 32'(4'b1110));
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_tick", 32'(tick), 32'd0);
    edges(15);
    check("pre_step_led", 32'(led), 32'(4'b1110));
    check("pre_step_tick", 32'(tick), 32'd0);
    edges(1);
    check("first_tick", 32'(tick), 32'd1);
    check("first_step_led", 32'(led), 32'(4'b1101));
    edges(16);
    check("second_step_led", 32'(led), 32'(4'b1011));

    // ROT_R, period 2.
    send(1, 2);
    check("rotr_load_ready", 32'(cmd_ready), 32'd0);
    edges(1);
    check("rotr_init_led", 32'(led), 32'(4'b0111));
    check("rotr_ready_back", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      edges(2);
      check("rotr_idle_tick", 32'(tick), 32'd0);
      edges(1);
      v = ~rr_pat[i];
      check("rotr_step_led", 32'(led), 32'(v));
      check("rotr_step_tick", 32'(tick), 32'd1);
    end

    // BOUNCE, period 0.
    send(2, 0);
    edges(1);
    v = ~bn_pat[0];
    check("bounce_init_led", 32'(led), 32'(v));
    for (int i = 1; i < 8; i++) begin
      edges(1);
      v = ~bn_pat[i];
      check("bounce_led", 32'(led), 32'(v));
      check("bounce_tick", 32'(tick), 32'd1);
    end

    // BLINK, period 1.
    send(3, 1);
    edges(1);
    check("blink_init_led", 32'(led), 32'(4'b0000));
    edges(1);
    check("blink_hold_tick", 32'(tick), 32'd0);
    edges(1);
    check("blink_led_off", 32'(led), 32'(4'b1111));
    check("blink_tick", 32'(tick), 32'd1);
    edges(2);
    check("blink_led_on", 32'(led), 32'(4'b0000));

    // Collision: command lands on the cycle a BOUNCE step is due.
    send(2, 3);
    edges(16);
    check("coll_pre_led", 32'(led), 32'(4'b0111));
    acc0 = dut_acc;
    cmd_mode = 2'd0;
    cmd_period = DW'(3);
    cmd_valid = 1'b1;
    edges(1);
    check("coll_step_led", 32'(led), 32'(4'b1011));
    check("coll_step_tick", 32'(tick), 32'd1);
    check("coll_ready_e1", 32'(cmd_ready), 32'd0);
    cmd_mode = 2'd2;
    cmd_period = DW'(0);
    edges(1);
    check("coll_load_led", 32'(led), 32'(4'b1110));
    check("coll_ready_e2", 32'(cmd_ready), 32'd1);
    edges(1);
    check("coll_ready_e3", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    edges(1);
    check("coll_ready_e4", 32'(cmd_ready), 32'd1);
    check("coll_accepts", 32'(dut_acc - acc0), 32'd2);
    edges(1);
    check("coll_dir_cleared", 32'(led), 32'(4'b1101));
    edges(3);
    check("bounce_back_led", 32'(led), 32'(4'b1011));

    // Async reset mid-BOUNCE with dir = 1.
    #2 rst = 1'b1;
    #1;
    check("arst_led", 32'(led), 32'(4'b1110));
    check("arst_ready", 32'(cmd_ready), 32'd1);
    check("arst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    edges(16);
    check("arst_step_led", 32'(led), 32'(4'b1101));
    check("arst_step_tick", 32'(tick), 32'd1);

    // Async reset during LOAD.
    send(1, 2);
    #2 rst = 1'b1;
    #1;
    check("aload_led", 32'(led), 32'(4'b1110));
    check("aload_ready", 32'(cmd_ready), 32'd1);
    check("aload_tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    edges(16);
    check("aload_step_led", 32'(led), 32'(4'b1101));
    edges(1);
    check("aload_tick_drop", 32'(tick), 32'd0);

    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Programmable LED pattern scheduler for the board's LED bank. It divides `clk` down to a step tick and advances an N-bit pattern on each tick according to one of four modes. Mode and step period are reconfigured at run time through a valid/ready command port. It replaces the fixed free-running rotator as the block that sequences the LED datapath, and drives the LED pins directly (active-low).

## Interface

- `N_LEDS`, default 6: number of LEDs driven; must be ≥ 2.
- `DIV_WIDTH`, default 22: width of the step-period prescaler.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_mode`  in  2  requested mode: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK.
- `cmd_period`  in  DIV_WIDTH  step period; one tick every `cmd_period`+1 cycles.
- `tick`  out  1  registered one-cycle pulse, high in every cycle in which the pattern steps.
- `led`  out  N_LEDS  LED drive, active-low: `led` = ~`pat`.

## Operation

- **Registers**
  - `state` ∈ {RUN, LOAD}
  - `mode[1:0]`
  - `period[DIV_WIDTH-1:0]`
  - `cnt[DIV_WIDTH-1:0]`
  - `pat[N_LEDS-1:0]`
  - `dir`: 0 = left, 1 = right
- **Reset values**
  - `state` = RUN, `mode` = ROT_L, `period` = all ones, `cnt` = 0.
  - `pat` = 1 (LSB only), `dir` = 0.
  - Resulting outputs: `tick` = 0, `cmd_ready` = 1, `led` = ~1.
- **Prescaler**
  - In RUN: if `cnt` == `period`, then `cnt` ← 0 and a step occurs; otherwise `cnt` ← `cnt`+1.
  - `period` = 0 gives a step every cycle.
  - Unsigned compare; `cnt` never exceeds `period`.
- **Step rules** (applied on each step, RUN only)
  - ROT_L: `pat` ← {`pat`[N-2:0], `pat`[N-1]}.
  - ROT_R: `pat` ← {`pat`[0], `pat`[N-1:1]}.
  - BOUNCE:
    - With `dir` = 0: if `pat`[N-1] is set, then `dir` ← 1 and `pat` ← `pat`>>1; otherwise `pat` ← `pat`<<1.
    - With `dir` = 1: mirror image, turning at `pat`[0].
    - No end value repeats.
  - BLINK: `pat` ← ~`pat`.
- **Command handshake**
  - `cmd_ready` = (`state` == RUN).
  - A command is accepted on an edge where `cmd_valid` && `cmd_ready`.
  - On acceptance: `mode` ← `cmd_mode`, `period` ← `cmd_period`, `state` ← LOAD.
- **LOAD state** (exactly one cycle; `cmd_ready` = 0, no step, `tick` not asserted)
  - On exit: `cnt` ← 0, `dir` ← 0, `state` ← RUN.
  - `pat` is initialised by mode: ROT_L/BOUNCE → 1; ROT_R → MSB only; BLINK → all ones.
- **Simultaneous step and accept**: if a command is accepted in a cycle where a step is due, that step still executes under the old mode. LOAD then overwrites `pat`.
- `cmd_valid` held high across LOAD yields a new acceptance on the first RUN cycle after LOAD. The bench treats this as a second command.
- `cmd_mode` and `cmd_period` are sampled only at acceptance.

## Timing

- `tick` and `pat` update on the same edge. `tick` is high in the cycle after the step edge, coincident with the new `led` value.
- Reset: after release, the first step occurs on the edge ending cycle 2^DIV_WIDTH − 1 (counting from cycle 0).
- Command latency:
  - Accept edge A.
  - LOAD cycle; the initial pattern is visible on `led` after edge A+1.
  - The first step occurs `period`+1 cycles after A+1.
- Back-to-back commands: at most one acceptance per 2 cycles.
- Asynchronous reset asserted mid-operation forces all reset values immediately, without a clock edge, including in LOAD.

## Test plan

Parameters for all scenarios: `N_LEDS` = 4, `DIV_WIDTH` = 4.

- **Reset, no command**: `led` = 1110 and `cmd_ready` = 1. After 16 cycles, `tick` pulses once and `led` = 1101; the next change is 16 cycles later (1011).
- **ROT_R, period 2**:
  - Command: mode 1, period 2.
  - `cmd_ready` is low for 1 cycle; `led` = 0111 after LOAD.
  - `pat` then steps every 3 cycles through 1000, 0100, 0010, 0001, 1000.
- **BOUNCE, period 0**: `pat` per cycle is 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; `tick` is high every cycle after LOAD.
- **BLINK, period 1**: `led` alternates 0000 / 1111 every 2 cycles; `tick` is high on alternate cycles.
- **Command collision**:
  - Command ROT_L issued on the exact cycle `cnt` == `period` in BOUNCE.
  - Required: the BOUNCE step executes, then LOAD sets `pat` = 0001 and `dir` = 0.
  - `cmd_valid` held high for 3 cycles gives exactly 2 acceptances, separated by one `cmd_ready` = 0 cycle.
- **Async reset mid-operation**: `rst` asserted mid-BOUNCE (`dir` = 1) and mid-LOAD. Required: `led` = 1110, `cmd_ready` = 1 and `tick` = 0 before any clock edge. After release, the behaviour matches the reset scenario.
